mem_master: RTL and testbench

- Bus initiator for the single-port memory valid/ready protocol; drives valid, wr_rd, addr and wdata, and samples rdata and ready.
- Accepts one burst command at a time: op, base address, beat count, seed data.
- Issues the burst as incrementing-address accesses and returns read data on a response port.
- Replaces the testbench BFM as the synthesizable traffic source in front of the memory block.

---
 rtl/mem_master_pkg.sv | 21 ++
 rtl/mem_master_wdog.sv | 29 ++
 rtl/mem_master.sv | 178 +++++++++++++++++
 tb/tb_mem_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and constants for the mem_master burst initiator.
package mem_master_pkg;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Memory operation encoding on wr_rd.
    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    // Default widths matching the memory block this master fronts.
    localparam int ADDR_WIDTH_DEF     = 16;
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int LEN_WIDTH_DEF      = 8;
    localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mem_master_wdog.sv
// Ready-wait watchdog for mem_master: counts consecutive stalled request
// cycles and flags a timeout when TIMEOUT_CYCLES stalled cycles have elapsed.
// Only instantiated when MEM_MASTER_TIMEOUT_EN is defined.
module mem_master_wdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stall_i,
    output logic timeout_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    // Timeout fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle.
    assign timeout_o = stall_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: any non-stalled cycle (handshake or idle) clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i || !stall_i || timeout_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_master.sv
// mem_master: synthesizable burst initiator for the single-port memory
// valid/ready protocol. Accepts one burst command at a time, issues
// incrementing-address beats and returns read data on a response port.
// Optional feature macro: MEM_MASTER_TIMEOUT_EN (ready-wait watchdog that
// aborts a stalled burst and pulses err_o). Without it err_o is tied 0.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // Command port
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    // Memory port
    output logic                  valid_o,
    output logic                  wr_rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  ready_i,
    // Response / status port
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int CNT_W = LEN_WIDTH + 1;

    state_t                state_q;
    logic                  valid_q;
    logic                  wr_rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [CNT_W-1:0]      beats_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_last_q;
    logic                  done_q;
    logic                  beat_fire;
    logic                  last_beat;

    // A beat completes on every edge where the request is valid and ready.
    assign beat_fire = (state_q == ACCESS) && valid_q && ready_i;
    // Beats remaining includes the one currently on the bus.
    assign last_beat = (beats_q == CNT_W'(1));
    // Address and data advance modulo their widths.
    assign addr_d    = addr_q + ADDR_WIDTH'(1);
    assign wdata_d   = wdata_q + DATA_WIDTH'(1);

    // Command is accepted only in IDLE and never while reset is asserted.
    assign cmd_ready_o = (state_q == IDLE) && !rst_i;

    assign valid_o     = valid_q;
    assign wr_rd_o     = wr_rd_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_last_o  = rsp_last_q;
    assign done_o      = done_q;

`ifdef MEM_MASTER_TIMEOUT_EN
    logic wdog_stall;
    logic wdog_timeout;
    logic err_q;

    // Only a pending request that the memory refuses counts as a stall.
    assign wdog_stall = (state_q == ACCESS) && valid_q && !ready_i;

    mem_master_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stall_i   (wdog_stall),
        .timeout_o (wdog_timeout)
    );

    assign err_o = err_q;
`else
    logic unused_timeout_cfg;

    // Without the watchdog the timeout limit has no effect.
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err_o = 1'b0;
`endif

    // Burst sequencer with registered bus, response and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            wr_rd_q     <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // Status and response strobes are single-cycle pulses.
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        state_q <= ACCESS;
                        valid_q <= 1'b1;
                        wr_rd_q <= cmd_wr_rd_i;
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        beats_q <= {1'b0, cmd_len_i} + CNT_W'(1);
                    end
                end

                ACCESS: begin
                    if (beat_fire) begin
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        beats_q <= beats_q - CNT_W'(1);
                        if (wr_rd_q != OP_WR) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rdata_i;
                            rsp_last_q  <= last_beat;
                        end
                        if (last_beat) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            wr_rd_q <= OP_RD;
                            done_q  <= 1'b1;
                        end
                    end
`ifdef MEM_MASTER_TIMEOUT_EN
                    else if (wdog_timeout) begin
                        // Abort straight to IDLE; no done pulse for an aborted burst.
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        wr_rd_q <= OP_RD;
                        err_q   <= 1'b1;
                    end
`endif
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    wr_rd_q <= OP_RD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
`timescale 1ns/1ps
module tb_mem_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int TO = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_wr_rd_i;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          valid_o;
    logic          wr_rd_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic [DW-1:0] rdata_i;
    logic          ready_i;
    logic          rsp_valid_o;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_last_o;
    logic          done_o;
    logic          err_o;

    mem_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_wr_rd_i (cmd_wr_rd_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_wdata_i (cmd_wdata_i),
        .valid_o     (valid_o),
        .wr_rd_o     (wr_rd_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_i     (rdata_i),
        .ready_i     (ready_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_last_o  (rsp_last_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rsp_t;

    beat_t exp_beat_q[$];
    beat_t obs_beat_q[$];
    rsp_t  exp_rsp_q[$];
    rsp_t  obs_rsp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt = 0;
    int done_cnt  = 0;
    int done_cyc  = -1;
    int err_cnt   = 0;
    int err_cyc   = -1;

    logic [DW-1:0] mem [256];

    // Memory model: combinational read, write on handshake.
    assign rdata_i = mem[addr_o[7:0]];

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (valid_o === 1'b1 && ready_i === 1'b1 && wr_rd_o === 1'b1)
            mem[addr_o[7:0]] <= wdata_o;
    end

    // Monitor: logs bus beats, responses and status pulses mid-cycle.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) begin
            valid_cnt++;
            if (ready_i === 1'b1) obs_beat_q.push_back('{wr_rd_o, addr_o, wdata_o, cyc});
        end
        if (rsp_valid_o === 1'b1) obs_rsp_q.push_back('{rsp_data_o, rsp_last_o});
        if (done_o === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err_o === 1'b1) begin err_cnt++; err_cyc = cyc; end
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [DW-1:0] seed, output int hs);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_wr_rd_i = wr;
        cmd_addr_i  = a;
        cmd_len_i   = len;
        cmd_wdata_i = seed;
        while (n < 200) begin
            @(negedge clk_i);
            if (cmd_ready_o === 1'b1) break;
            n++;
        end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        hs = cyc;
    endtask

    task automatic wait_idle(input int limit, output bit ok, output int at_cyc);
        ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_i); #1;
            if (cmd_ready_o === 1'b1) begin ok = 1'b1; at_cyc = cyc; break; end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cmd_valid_i = 1'b1; cmd_wr_rd_i = 1'b1;
        cmd_addr_i = '0; cmd_len_i = '0; cmd_wdata_i = '0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready_o); end
        total++;
        if ({valid_o, wr_rd_o, addr_o, wdata_o, rsp_valid_o, rsp_data_o, rsp_last_o, done_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%b wr=%b addr=%h wdata=%h rsp_v=%b rsp_d=%h last=%b done=%b err=%b want all 0",
                     valid_o, wr_rd_o, addr_o, wdata_o, rsp_valid_o, rsp_data_o, rsp_last_o, done_o, err_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; cmd_valid_i = 1'b0;
        @(negedge clk_i);
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", valid_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_write();
        int hs, rdy, d0; bit ok; beat_t e, o;
        obs_beat_q.delete(); obs_rsp_q.delete(); exp_beat_q.delete();
        ready_i = 1'b1; d0 = done_cnt;
        send_cmd(1'b1, 16'h0010, 8'd3, 32'hA000_0000, hs);
        for (int k = 0; k < 4; k++)
            exp_beat_q.push_back('{1'b1, AW'(16'h0010 + k), DW'(32'hA000_0000 + k), hs + k});
        wait_idle(40, ok, rdy);
        total++; if (!ok) begin bad++; $display("FAIL write_idle_timeout: cmd_ready never returned"); end
        total++; if (obs_beat_q.size() !== 4) begin bad++; $display("FAIL write_beat_count: got %0d want 4", obs_beat_q.size()); end
        while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); o = obs_beat_q.pop_front();
            total++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL write_beat: got wr=%b a=%h d=%h c=%0d want wr=%b a=%h d=%h c=%0d",
                         o.wr, o.addr, o.data, o.cyc, e.wr, e.addr, e.data, e.cyc);
            end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL write_done_count: got %0d want 1", done_cnt - d0); end
        total++; if (done_cyc !== hs + 4) begin bad++; $display("FAIL write_done_cycle: got %0d want %0d", done_cyc, hs + 4); end
        total++; if (rdy !== hs + 5) begin bad++; $display("FAIL write_ready_cycle: got %0d want %0d", rdy, hs + 5); end
        total++; if (obs_rsp_q.size() !== 0) begin bad++; $display("FAIL write_no_rsp: got %0d rsp pulses want 0", obs_rsp_q.size()); end
    endtask

    task automatic test_read();
        int hs, rdy; bit ok; rsp_t e, o; beat_t b;
        obs_beat_q.delete(); obs_rsp_q.delete(); exp_rsp_q.delete();
        ready_i = 1'b1;
        send_cmd(1'b0, 16'h0010, 8'd3, 32'h0, hs);
        for (int k = 0; k < 4; k++) exp_rsp_q.push_back('{DW'(32'hA000_0000 + k), (k == 3)});
        wait_idle(40, ok, rdy);
        total++; if (!ok) begin bad++; $display("FAIL read_idle_timeout: cmd_ready never returned"); end
        total++; if (obs_rsp_q.size() !== 4) begin bad++; $display("FAIL read_rsp_count: got %0d want 4", obs_rsp_q.size()); end
        while (exp_rsp_q.size() > 0 && obs_rsp_q.size() > 0) begin
            e = exp_rsp_q.pop_front(); o = obs_rsp_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin
                bad++;
                $display("FAIL read_rsp: got d=%h last=%b want d=%h last=%b", o.data, o.last, e.data, e.last);
            end
        end
        if (obs_beat_q.size() > 0) begin
            b = obs_beat_q[0];
            total++; if (b.wr !== 1'b0) begin bad++; $display("FAIL read_wr_rd: got %b want 0", b.wr); end
        end
    endtask

    task automatic test_stall();
        int hs, rdy, d0; bit ok; beat_t e, o;
        obs_beat_q.delete(); exp_beat_q.delete();
        ready_i = 1'b0; d0 = done_cnt;
        send_cmd(1'b1, 16'h0040, 8'd1, 32'h5555_0000, hs);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++;
            if (valid_o !== 1'b1 || wr_rd_o !== 1'b1 || addr_o !== 16'h0040 || wdata_o !== 32'h5555_0000) begin
                bad++;
                $display("FAIL stall_hold: got v=%b wr=%b a=%h d=%h want v=1 wr=1 a=0040 d=55550000",
                         valid_o, wr_rd_o, addr_o, wdata_o);
            end
            @(posedge clk_i);
        end
        #1 ready_i = 1'b1;
        exp_beat_q.push_back('{1'b1, 16'h0040, 32'h5555_0000, hs + 3});
        exp_beat_q.push_back('{1'b1, 16'h0041, 32'h5555_0001, hs + 4});
        wait_idle(40, ok, rdy);
        total++; if (obs_beat_q.size() !== 2) begin bad++; $display("FAIL stall_beat_count: got %0d want 2", obs_beat_q.size()); end
        while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); o = obs_beat_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL stall_beat: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int hs, rdy; bit ok; beat_t e, o;
        obs_beat_q.delete(); exp_beat_q.delete();
        ready_i = 1'b1;
        send_cmd(1'b1, 16'hFFFE, 8'd2, 32'hFFFF_FFFF, hs);
        exp_beat_q.push_back('{1'b1, 16'hFFFE, 32'hFFFF_FFFF, hs});
        exp_beat_q.push_back('{1'b1, 16'hFFFF, 32'h0000_0000, hs + 1});
        exp_beat_q.push_back('{1'b1, 16'h0000, 32'h0000_0001, hs + 2});
        wait_idle(40, ok, rdy);
        total++; if (obs_beat_q.size() !== 3) begin bad++; $display("FAIL wrap_beat_count: got %0d want 3", obs_beat_q.size()); end
        while (exp_beat_q.size() > 0 && obs_beat_q.size() > 0) begin
            e = exp_beat_q.pop_front(); o = obs_beat_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
                bad++;
                $display("FAIL wrap_beat: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs1, hs2, rdy; bit ok;
        ready_i = 1'b1;
        send_cmd(1'b1, 16'h0060, 8'd0, 32'h0000_0060, hs1);
        send_cmd(1'b1, 16'h0061, 8'd0, 32'h0000_0061, hs2);
        wait_idle(40, ok, rdy);
        total++; if (hs2 - hs1 !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d cycles want 3", hs2 - hs1); end
    endtask

    task automatic test_reset_mid();
        int hs, rdy, v0, d0; bit ok; rsp_t o;
        obs_beat_q.delete(); obs_rsp_q.delete();
        ready_i = 1'b1; d0 = done_cnt;
        send_cmd(1'b1, 16'h0080, 8'd7, 32'h1234_0000, hs);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        total++; if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL midrst_cmd_ready_in_reset: got %b want 0", cmd_ready_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        v0 = valid_cnt;
        @(negedge clk_i);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
        total++; if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready_o); end
        repeat (6) @(negedge clk_i);
        #1;
        total++; if (valid_cnt !== v0) begin bad++; $display("FAIL midrst_no_valid: got %0d extra valid cycles want 0", valid_cnt - v0); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL midrst_no_done: got %0d done pulses want 0", done_cnt - d0); end
        total++; if (obs_beat_q.size() !== 2) begin bad++; $display("FAIL midrst_beats: got %0d want 2", obs_beat_q.size()); end
        @(posedge clk_i); #1;
        obs_rsp_q.delete(); exp_rsp_q.delete();
        send_cmd(1'b0, 16'h0010, 8'd0, 32'h0, hs);
        exp_rsp_q.push_back('{32'hA000_0000, 1'b1});
        wait_idle(20, ok, rdy);
        total++; if (!ok || done_cnt - d0 !== 1) begin bad++; $display("FAIL midrst_followup_done: got %0d done ok=%b want 1 done", done_cnt - d0, ok); end
        total++; if (obs_rsp_q.size() !== 1) begin bad++; $display("FAIL midrst_followup_rsp_count: got %0d want 1", obs_rsp_q.size()); end
        if (obs_rsp_q.size() > 0) begin
            o = obs_rsp_q.pop_front();
            total++;
            if (o.data !== exp_rsp_q[0].data || o.last !== exp_rsp_q[0].last) begin
                bad++;
                $display("FAIL midrst_followup_rsp: got d=%h last=%b want d=%h last=%b", o.data, o.last, exp_rsp_q[0].data, exp_rsp_q[0].last);
            end
        end
    endtask

    task automatic test_timeout();
        int hs, v0, d0, e0;
        ready_i = 1'b0; v0 = valid_cnt; d0 = done_cnt; e0 = err_cnt;
        send_cmd(1'b0, 16'h0030, 8'd1, 32'h0, hs);
        v0 = valid_cnt;
`ifdef MEM_MASTER_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i); #1;
            if (err_cnt != e0) break;
        end
        total++; if (err_cyc !== hs + TO) begin bad++; $display("FAIL timeout_err_cycle: got %0d want %0d", err_cyc, hs + TO); end
        total++; if (valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin bad++; $display("FAIL timeout_abort: got valid=%b cmd_ready=%b want 0/1", valid_o, cmd_ready_o); end
        total++; if (valid_cnt - v0 !== TO) begin bad++; $display("FAIL timeout_valid_cycles: got %0d want %0d", valid_cnt - v0, TO); end
        repeat (5) @(negedge clk_i);
        #1;
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_err_once: got %0d want 1", err_cnt - e0); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt - d0); end
        @(posedge clk_i); #1;
`else
        repeat (TO + 16) @(negedge clk_i);
        #1;
        total++; if (err_cnt !== e0) begin bad++; $display("FAIL no_timeout_err: got %0d err pulses want 0", err_cnt - e0); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL no_timeout_valid: got %b want 1", valid_o); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL no_timeout_done: got %0d want 0", done_cnt - d0); end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
